conv_result_collector: RTL and testbench

- Receive end of the Conv_acc output interface: captures every o_Data word qualified by o_Data_en.
- Buffers captured words in a FIFO and re-emits them on a valid/ready stream toward the DMA/PS side.
- Marks frame boundaries with a last flag; raises almost-full so the upstream feeder can pause input, since the accelerator itself cannot stall.
- Flags dropped results with a sticky overflow bit.

---
 rtl/conv_result_collector.sv | 149 ++++++++++++++
 tb/tb_conv_result_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conv_result_collector.sv
// Result collector for the Conv_acc output: captures qualified result words into a
// circular buffer and replays them on a valid/ready stream with frame-end marking.
module conv_result_collector #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 9,
    parameter int AF_MARGIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        i_Data,
    input  logic                     i_Data_en,
    input  logic                     i_clear,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_last,
    output logic                     o_almost_full,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [15:0]              o_frames
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_NORMAL = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    logic [DATA_W:0]   r_mem [DEPTH];
    logic [AW:0]       r_wr;
    logic [AW:0]       r_rd;
    logic [FW-1:0]     r_fcnt;
    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_af;
    logic              r_ovf;
    logic [LW-1:0]     r_level;
    logic [15:0]       r_frames;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_last_in;
    logic [AW:0]       w_wr_next;
    logic [AW:0]       w_rd_next;
    logic [LW-1:0]     w_level_next;
    logic              w_empty_next;
    logic              w_full_next;
    logic              w_bypass;
    logic [DATA_W:0]   w_head;
    logic              w_af;

    // Next-state pointer, level and head-of-queue computation.
    always_comb begin
        w_pop        = r_valid & i_ready & ~i_clear;
        w_push       = i_Data_en & ~i_clear & ((r_state != ST_FULL) | w_pop);
        w_drop       = i_Data_en & ~i_clear & (r_state == ST_FULL) & ~w_pop;
        w_last_in    = (r_fcnt == FW'(FRAME_LEN - 1));
        w_wr_next    = r_wr + LW'(w_push);
        w_rd_next    = r_rd + LW'(w_pop);
        w_level_next = w_wr_next - w_rd_next;
        w_empty_next = (w_wr_next == w_rd_next);
        w_full_next  = (w_wr_next[AW] != w_rd_next[AW]) &&
                       (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
        // A word written into a queue that would otherwise be empty goes straight to the output register.
        w_bypass     = w_push && (r_wr == w_rd_next);
        if (w_bypass) begin
            w_head = {w_last_in, i_Data};
        end else begin
            w_head = r_mem[w_rd_next[AW-1:0]];
        end
        w_af = ({1'b0, w_level_next} + (LW+1)'(AF_MARGIN)) >= (LW+1)'(DEPTH);
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= {w_last_in, i_Data};
        end
    end

    // Control state, registered outputs and status counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_fcnt   <= '0;
            r_state  <= ST_EMPTY;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_af     <= 1'b0;
            r_ovf    <= 1'b0;
            r_level  <= '0;
            r_frames <= 16'd0;
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_fcnt  <= '0;
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
            r_level <= '0;
        end else begin
            r_wr    <= w_wr_next;
            r_rd    <= w_rd_next;
            r_level <= w_level_next;
            r_valid <= ~w_empty_next;
            r_last  <= w_head[DATA_W];
            r_data  <= w_head[DATA_W-1:0];
            r_af    <= w_af;
            r_ovf   <= r_ovf | w_drop;
            if (w_push && w_last_in) begin
                r_fcnt   <= '0;
                r_frames <= r_frames + 16'd1;
            end else if (w_push) begin
                r_fcnt <= r_fcnt + FW'(1);
            end else begin
                r_fcnt <= r_fcnt;
            end
            case (r_state)
                ST_EMPTY:  r_state <= w_push ? ST_NORMAL : ST_EMPTY;
                ST_NORMAL: r_state <= w_full_next  ? ST_FULL  :
                                      w_empty_next ? ST_EMPTY : ST_NORMAL;
                ST_FULL:   r_state <= w_full_next ? ST_FULL : ST_NORMAL;
                default:   r_state <= ST_EMPTY;
            endcase
        end
    end

    assign o_data        = r_data;
    assign o_valid       = r_valid;
    assign o_last        = r_last;
    assign o_almost_full = r_af;
    assign o_overflow    = r_ovf;
    assign o_level       = r_level;
    assign o_frames      = r_frames;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed self-checking bench for conv_result_collector.
module tb_conv_result_collector;

    logic        clk;
    logic        rst;
    logic [63:0] i_Data;
    logic        i_Data_en;
    logic        i_clear;
    logic [63:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;
    logic        o_almost_full;
    logic        o_overflow;
    logic [4:0]  o_level;
    logic [15:0] o_frames;

    int n_checks = 0;
    int n_pass   = 0;

    conv_result_collector #(
        .DATA_W(64), .DEPTH(16), .FRAME_LEN(9), .AF_MARGIN(4)
    ) dut (
        .clk(clk), .rst(rst), .i_Data(i_Data), .i_Data_en(i_Data_en),
        .i_clear(i_clear), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_last(o_last), .o_almost_full(o_almost_full), .o_overflow(o_overflow),
        .o_level(o_level), .o_frames(o_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        rst       = 1'b0;
        i_Data    = 64'd0;
        i_Data_en = 1'b0;
        i_clear   = 1'b0;
        i_ready   = 1'b0;
        #12;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_level", {59'd0, o_level}, 64'd0);
        chk("rst_frames", {48'd0, o_frames}, 64'd0);
        chk("rst_af_ovf", {62'd0, o_almost_full, o_overflow}, 64'd0);
        rst = 1'b1;
        tick();

        // 1: nine streamed words, last on the ninth
        i_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            i_Data = 64'(k); i_Data_en = 1'b1;
            tick();
            chk("t1_data", o_data, 64'(k));
            chk("t1_valid", {63'd0, o_valid}, 64'd1);
            chk("t1_last", {63'd0, o_last}, (k == 9) ? 64'd1 : 64'd0);
        end
        i_Data_en = 1'b0;
        tick();
        chk("t1_empty", {63'd0, o_valid}, 64'd0);
        chk("t1_frames", {48'd0, o_frames}, 64'd1);

        // 2: fill while stalled, then overflow
        i_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            i_Data = 64'h100 + 64'(k); i_Data_en = 1'b1;
            tick();
            chk("t2_level", {59'd0, o_level}, 64'(k + 1));
            chk("t2_af", {63'd0, o_almost_full}, (k + 1 >= 12) ? 64'd1 : 64'd0);
            chk("t2_ovf0", {63'd0, o_overflow}, 64'd0);
        end
        i_Data = 64'h1FF;
        tick();
        chk("t2_ovf", {63'd0, o_overflow}, 64'd1);
        chk("t2_level16", {59'd0, o_level}, 64'd16);
        chk("t2_head", o_data, 64'h100);
        i_Data_en = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t2_dvalid", {63'd0, o_valid}, 64'd1);
            chk("t2_ddata", o_data, 64'h100 + 64'(k));
            chk("t2_dlast", {63'd0, o_last}, (k == 8) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t2_drained", {63'd0, o_valid}, 64'd0);
        chk("t2_frames", {48'd0, o_frames}, 64'd2);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("clr_ovf", {63'd0, o_overflow}, 64'd0);
        chk("clr_level", {59'd0, o_level}, 64'd0);
        chk("clr_frames", {48'd0, o_frames}, 64'd2);

        // 3: full with simultaneous write and pop
        i_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            i_Data = 64'h300 + 64'(k); i_Data_en = 1'b1;
            tick();
        end
        i_Data = 64'h3FF; i_ready = 1'b1;
        tick();
        chk("t3_ovf", {63'd0, o_overflow}, 64'd0);
        chk("t3_level", {59'd0, o_level}, 64'd16);
        chk("t3_head", o_data, 64'h301);
        i_Data_en = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("t3_ddata", o_data, (k == 16) ? 64'h3FF : 64'h300 + 64'(k));
            chk("t3_dlast", {63'd0, o_last}, (k == 8) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t3_frames", {48'd0, o_frames}, 64'd3);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;

        // 4: frame marking across twenty words, then after a clear
        for (int k = 0; k < 20; k++) begin
            i_Data = 64'h400 + 64'(k); i_Data_en = 1'b1;
            tick();
            chk("t4_data", o_data, 64'h400 + 64'(k));
            chk("t4_last", {63'd0, o_last}, (k == 8 || k == 17) ? 64'd1 : 64'd0);
        end
        i_Data_en = 1'b0; i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("t4_frames5", {48'd0, o_frames}, 64'd5);
        for (int k = 0; k < 9; k++) begin
            i_Data = 64'h500 + 64'(k); i_Data_en = 1'b1;
            tick();
            chk("t4_last2", {63'd0, o_last}, (k == 8) ? 64'd1 : 64'd0);
        end
        i_Data_en = 1'b0;
        tick();
        chk("t4_frames6", {48'd0, o_frames}, 64'd6);

        // 5: ready toggling during a burst
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            i_Data_en = (c < 9);
            i_Data    = 64'h600 + 64'(c);
            i_ready   = (c % 2 == 0);
            if (o_valid) begin
                chk("t5_data", o_data, 64'h600 + 64'(idx));
                chk("t5_last", {63'd0, o_last}, (idx == 8) ? 64'd1 : 64'd0);
                if (i_ready) idx++;
            end
            tick();
            if (c >= 9 && idx >= 9) break;
        end
        i_Data_en = 1'b0;
        chk("t5_count", 64'(idx), 64'd9);
        chk("t5_empty", {63'd0, o_valid}, 64'd0);

        // 6: async reset mid-stream
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_Data = 64'h700 + 64'(k); i_Data_en = 1'b1;
            tick();
        end
        i_Data_en = 1'b0;
        chk("t6_level5", {59'd0, o_level}, 64'd5);
        #2 rst = 1'b0;
        #1;
        chk("t6_rvalid", {63'd0, o_valid}, 64'd0);
        chk("t6_rdata", o_data, 64'd0);
        chk("t6_rlevel", {59'd0, o_level}, 64'd0);
        chk("t6_rframes", {48'd0, o_frames}, 64'd0);
        rst = 1'b1;
        i_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            i_Data = 64'h777 + 64'(k); i_Data_en = 1'b1;
            tick();
            chk("t6_data", o_data, 64'h777 + 64'(k));
            chk("t6_last", {63'd0, o_last}, (k == 8) ? 64'd1 : 64'd0);
        end
        i_Data_en = 1'b0;
        tick();
        chk("t6_frames", {48'd0, o_frames}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
